// File: rtl/bnn_pkg.sv
// bnn_pkg: shared loader state encoding, default image/weight sizes and bank-select constants
package bnn_pkg;
  typedef enum logic [1:0] {IDLE, PIX, WGT, DONE} state_t;
  localparam int DEF_PIX_BYTES = 98;
  localparam int DEF_WGT_BYTES = 128;
  localparam logic SEL_PIX = 1'b0;
  localparam logic SEL_WGT = 1'b1;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: two-flop synchronizer plus history flop for the byte strobe, with din delayed alongside
//   clk, rst_n : clock, synchronous active-low reset
//   strobe, din: asynchronous strobe pin and its byte bus
//   rise, data : one-cycle rising-edge flag and the byte aligned with it
module sync_edge (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       strobe,
  input  logic [7:0] din,
  output logic       rise,
  output logic [7:0] data
);
  logic s1, s2, s3;
  logic [7:0] d1, d2;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {s1, s2, s3} <= '0;
      d1 <= '0;
      d2 <= '0;
    end else begin
      {s1, s2, s3} <= {strobe, s1, s2};
      d1 <= din;
      d2 <= d1;
    end
  end
  assign rise = s2 & ~s3;
  assign data = d2;
endmodule

// File: rtl/bnn_loader.sv
// bnn_loader: streams strobed bytes into the pixel bank, then the weight bank, then reports done
//   clk, rst_n      : clock, synchronous active-low reset
//   load_en         : top FSM is in LOAD
//   strobe, din     : asynchronous byte strobe and byte bus
//   wr_en/sel/addr/data : one-cycle register-file write (sel 0 pixels, 1 weights)
//   load_done       : all bytes written; overrun: sticky strobe-while-not-accepting
module bnn_loader
  import bnn_pkg::*;
#(
  parameter int N_PIX_BYTES = DEF_PIX_BYTES,
  parameter int N_WGT_BYTES = DEF_WGT_BYTES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_en,
  input  logic       strobe,
  input  logic [7:0] din,
  output logic       wr_en,
  output logic       wr_sel,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       load_done,
  output logic       overrun
);
  if (N_PIX_BYTES < 1 || N_PIX_BYTES > 256 || N_WGT_BYTES < 1 || N_WGT_BYTES > 256) begin : g_bad_param
    $error("bnn_loader: N_PIX_BYTES and N_WGT_BYTES must be in 1..256");
  end
  state_t state, next_state;
  logic [7:0] count;
  logic rise, accept, last, miss;
  logic [7:0] data;
  sync_edge u_sync (.clk(clk), .rst_n(rst_n), .strobe(strobe), .din(din), .rise(rise), .data(data));
  // an edge arriving as load_en falls is dropped silently, neither written nor flagged
  always_comb begin
    accept = rise && load_en && (state == PIX || state == WGT);
    miss = rise && (state == IDLE || (state == DONE && load_en));
    last = count == (state == WGT ? 8'(N_WGT_BYTES - 1) : 8'(N_PIX_BYTES - 1));
    next_state = state;
    unique case (state)
      IDLE: next_state = load_en ? PIX : IDLE;
      PIX: next_state = !load_en ? IDLE : (accept && last) ? WGT : PIX;
      WGT: next_state = !load_en ? IDLE : (accept && last) ? DONE : WGT;
      DONE: next_state = load_en ? DONE : IDLE;
      default: next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      wr_en <= 1'b0;
      wr_sel <= SEL_PIX;
      wr_addr <= '0;
      wr_data <= '0;
      load_done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= next_state;
      wr_en <= accept;
      if (accept) begin
        wr_sel <= state == WGT ? SEL_WGT : SEL_PIX;
        wr_addr <= count;
        wr_data <= data;
      end
      count <= (state == IDLE || (accept && last)) ? 8'd0 : accept ? count + 8'd1 : count;
      // registered from DONE so it rises the cycle after the final write and drops with the exit
      load_done <= state == DONE && load_en;
      overrun <= overrun | miss;
    end
  end
endmodule

// File: tb/tb_bnn_loader.sv
// tb_bnn_loader: directed stimulus with a byte-stream model and a per-cycle write checker
module tb_bnn_loader;
  localparam int NP = 98;
  localparam int NW = 128;
  typedef struct packed {logic sel; logic [7:0] addr; logic [7:0] data;} wr_t;
  logic clk = 0, rst_n = 0, load_en = 0, strobe = 0;
  logic [7:0] din = 0;
  logic wr_en, wr_sel, load_done, overrun;
  logic [7:0] wr_addr, wr_data;
  int checks = 0, errors = 0;
  int pix = 0, wgt = 0;
  bit ld = 0, model_full = 0, mon = 0, done_due = 0;
  wr_t q[$];
  wr_t last_wr = '0;
  bnn_loader dut (.clk(clk), .rst_n(rst_n), .load_en(load_en), .strobe(strobe), .din(din),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .load_done(load_done), .overrun(overrun));
  always #5 clk = ~clk;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction
  task automatic step(int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask
  // model: the next byte goes to the next free pixel slot, then weight slot, else it is an overrun
  function automatic void expect_byte(logic [7:0] d);
    if (ld && pix < NP) begin
      q.push_back({1'b0, 8'(pix), d});
      pix++;
    end else if (ld && wgt < NW) begin
      q.push_back({1'b1, 8'(wgt), d});
      wgt++;
      model_full = wgt == NW;
    end
  endfunction
  task automatic send(logic [7:0] d);
    expect_byte(d);
    strobe = 1; din = d;
    step(2);
    strobe = 0;
    step(2);
  endtask
  always @(negedge clk) if (mon) begin
    wr_t e;
    if (done_due) begin
      chk("load_done_after_last", 32'(load_done), 1);
      done_due = 0;
    end
    if (load_done && !model_full) chk("load_done_early", 32'(load_done), 0);
    if (wr_en) begin
      if (q.size() == 0) chk("unexpected_wr_en", 32'(wr_en), 0);
      else begin
        e = q.pop_front();
        chk("wr_sel", 32'(wr_sel), 32'(e.sel));
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
        last_wr = e;
        if (e.sel && e.addr == 8'(NW - 1)) begin
          chk("load_done_at_last", 32'(load_done), 0);
          done_due = 1;
        end
      end
    end else chk("hold", 32'({wr_sel, wr_addr, wr_data}), 32'(last_wr));
  end
  initial begin
    logic [11:0] seen;
    step(2);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_sel", 32'(wr_sel), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_load_done", 32'(load_done), 0);
    chk("rst_overrun", 32'(overrun), 0);
    rst_n = 1; mon = 1;
    step(1);
    ld = 1; load_en = 1;
    step(2);
    for (int i = 0; i < NP; i++) send(8'(i));
    step(4);
    chk("pix_drain", 32'(q.size()), 0);
    chk("pix_last_addr", 32'(wr_addr), 97);
    chk("pix_last_data", 32'(wr_data), 97);
    chk("pix_last_sel", 32'(wr_sel), 0);
    for (int i = 0; i < NW; i++) send(8'hA5);
    step(4);
    chk("wgt_drain", 32'(q.size()), 0);
    chk("wgt_last_addr", 32'(wr_addr), 127);
    chk("wgt_last_data", 32'(wr_data), 32'h0A5);
    chk("wgt_last_sel", 32'(wr_sel), 1);
    chk("done_level", 32'(load_done), 1);
    chk("no_overrun_yet", 32'(overrun), 0);
    ld = 0; load_en = 0;
    step(1);
    chk("done_drop", 32'(load_done), 0);
    model_full = 0;
    step(2);
    send(8'h3C);
    step(4);
    chk("overrun_set", 32'(overrun), 1);
    chk("idle_no_write", 32'(q.size()), 0);
    pix = 0; wgt = 0; ld = 1; load_en = 1;
    step(2);
    for (int i = 0; i < 40; i++) send(8'(i + 7));
    ld = 0; load_en = 0;
    step(3);
    pix = 0; wgt = 0; ld = 1; load_en = 1;
    step(2);
    expect_byte(8'h5A);
    strobe = 1; din = 8'h5A;
    @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      seen[k] = wr_en;
      if (k == 8) strobe = 0;
    end
    chk("long_strobe_timing", 32'(seen), 32'h004);
    chk("restart_addr", 32'(wr_addr), 0);
    chk("restart_sel", 32'(wr_sel), 0);
    step(2);
    for (int i = 1; i < NP; i++) send(8'(255 - i));
    for (int i = 0; i < 50; i++) send(8'(i * 3));
    chk("mid_wgt_drain", 32'(q.size()), 0);
    chk("overrun_sticky", 32'(overrun), 1);
    mon = 0; rst_n = 0;
    step(1);
    chk("mid_rst_wr_en", 32'(wr_en), 0);
    chk("mid_rst_sel", 32'(wr_sel), 0);
    chk("mid_rst_addr", 32'(wr_addr), 0);
    chk("mid_rst_data", 32'(wr_data), 0);
    chk("mid_rst_done", 32'(load_done), 0);
    chk("mid_rst_overrun", 32'(overrun), 0);
    rst_n = 1;
    q.delete(); pix = 0; wgt = 0; last_wr = '0; done_due = 0; model_full = 0;
    step(1);
    chk("post_rst_wr_en", 32'(wr_en), 0);
    mon = 1;
    step(2);
    send(8'hC3);
    send(8'h11);
    step(4);
    chk("post_rst_drain", 32'(q.size()), 0);
    chk("post_rst_addr", 32'(wr_addr), 1);
    chk("post_rst_sel", 32'(wr_sel), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bnn_loader.md
BNN_LOADER -- requirements
Module: bnn_loader

Interface
REQ-001 SHALL have parameter N_PIX_BYTES, default 98, meaning 28x28 binary image packed 8 pixels per byte.
REQ-002 SHALL have parameter N_WGT_BYTES, default 128, meaning layer weight bytes loaded after the pixels.
REQ-003 SHALL have port clk  input  1  the single clock.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port load_en  input  1  high while the top FSM is in its LOAD state.
REQ-006 SHALL have port strobe  input  1  external byte strobe pin, asynchronous to clk, rising edge marks one byte.
REQ-007 SHALL have port din  input  8  external byte bus, stable from strobe rise until strobe fall.
REQ-008 SHALL have port wr_en  output  1  one-cycle write pulse to the pixel/weight register file.
REQ-009 SHALL have port wr_sel  output  1  target bank: 0 pixels, 1 weights.
REQ-010 SHALL have port wr_addr  output  8  byte address within the selected bank.
REQ-011 SHALL have port wr_data  output  8  byte to write.
REQ-012 SHALL have port load_done  output  1  level to the top FSM, high when all bytes are written.
REQ-013 SHALL have port overrun  output  1  sticky error: strobe seen while not accepting bytes.

Function
REQ-014 SHALL pass strobe through a 2-flop synchronizer plus one history flop, and detect rising edges as sync2 & ~sync3.
REQ-015 SHALL delay din through the same 2 stages, so that captured data aligns with the detected edge.
REQ-016 SHALL implement states IDLE, PIX, WGT, DONE.
REQ-017 IDLE: when load_en=1, go to PIX and clear the byte counter; otherwise stay in IDLE.
REQ-018 PIX: on each detected edge, write a byte with wr_sel=0 and wr_addr=count, then increment count; after byte N_PIX_BYTES-1, clear count and go to WGT.
REQ-019 WGT: same as PIX with wr_sel=1; after byte N_WGT_BYTES-1, go to DONE.
REQ-020 DONE: hold load_done=1; when load_en=0, go to IDLE and drop load_done in the same transition.
REQ-021 wr_en SHALL be registered; it is high for exactly one cycle, 3 clk edges after the first edge that samples strobe high.
REQ-022 wr_sel, wr_addr and wr_data SHALL be valid in the cycle wr_en is high; they hold their last values otherwise.
REQ-023 The last write of each bank SHALL use address N-1; the counter SHALL never wrap within a bank.
REQ-024 A detected edge in IDLE or DONE SHALL set overrun and SHALL NOT produce a write.
REQ-025 If load_en falls in PIX or WGT, the block SHALL abort to IDLE next cycle, write nothing further, and keep load_done=0.
REQ-026 An edge detected in the same cycle that load_en falls SHALL be dropped and SHALL NOT set overrun.
REQ-027 overrun SHALL clear only on reset.
REQ-028 Counter width SHALL be 8 bits; elaboration SHALL fail if either parameter exceeds 256 or is 0.

Reset
REQ-029 On a clk edge with rst_n=0, the block SHALL be in IDLE with count=0, synchronizer flops=0, wr_en=0, wr_sel=0, wr_addr=0, wr_data=0, load_done=0 and overrun=0.
REQ-030 A reset asserted mid-load SHALL discard progress, with no write in the cycle after reset.

Structure
REQ-031 The state enum, N_PIX_BYTES/N_WGT_BYTES defaults and bank-select constants SHALL live in the shared bnn_pkg package, also used by fsm.
REQ-032 The synchronizer plus edge detector SHALL be one sub-module, sync_edge, covering both strobe and data stages; the rest is flat.

Verification
REQ-033 Reset, then load_en=1 and 98 strobes with din=address -> 98 wr_en pulses, wr_sel=0, addr 0..97, data=addr; state becomes WGT.
REQ-034 Continue with 128 strobes, din=0xA5 -> wr_sel=1, addr 0..127, load_done=1 one cycle after the final write; load_en=0 -> load_done=0 next cycle.
REQ-035 Single strobe pulse held high for 10 cycles -> exactly one wr_en, 3 cycles after the first sampled-high edge.
REQ-036 Strobe while load_en=0 -> no wr_en, overrun=1, held until rst_n=0.
REQ-037 load_en dropped after 40 pixel bytes, then re-raised -> next write has wr_sel=0, addr 0; load_done never asserted.
REQ-038 rst_n=0 for one cycle during WGT byte 50 -> all outputs zero; subsequent load restarts at pixel addr 0.
